// File: rtl/gnpu_pkg.sv
// Shared types and widths for the gnpu A-operand buffer sequencing logic.
// TMMA_CNT_WIDTH may be overridden on the command line; it defaults to 8.
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif

package gnpu_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } a_bank_state_e;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } a_drain_state_e;

    localparam int TMMA_CNT_W = `TMMA_CNT_WIDTH;

endpackage

// File: rtl/a_buf_bank_fsm.sv
// Per-bank lifecycle tracker for the A-operand buffer: state plus latched tile length.
//
// state    | meaning
// ---------+--------------------------------------------------------
// EMPTY    | bank free, next beat starts a fill and latches len
// FILLING  | fill in progress, len frozen
// FULL     | tile complete, waiting for the array to be granted it
// DRAINING | array reading the tile; returns to EMPTY on release
module a_buf_bank_fsm
    import gnpu_pkg::*;
#(
    parameter int CNT_W = TMMA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_first,
    input  logic             fill_last,
    input  logic             grant,
    input  logic             release_bank,
    input  logic [CNT_W-1:0] len_in,
    output a_bank_state_e    state,
    output logic [CNT_W-1:0] len
);

    a_bank_state_e state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: begin
                // A 1-row tile completes on its first beat.
                if (fill_last) begin
                    state_nx = FULL;
                end else if (fill_first) begin
                    state_nx = FILLING;
                end
            end
            FILLING:  if (fill_last)    state_nx = FULL;
            FULL:     if (grant)        state_nx = DRAINING;
            DRAINING: if (release_bank) state_nx = EMPTY;
            default:  state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
        end else if (fill_first) begin
            len <= len_in;
        end
    end

endmodule

// File: rtl/a_buf_pingpong_ctrl.sv
// Ping-pong sequencer for the two-bank A-operand buffer: fills banks from the load
// stream and drains them to the systolic array. Optional replay via A_BUF_CTRL_REUSE_EN.
module a_buf_pingpong_ctrl
    import gnpu_pkg::*;
#(
    parameter int CNT_W     = `TMMA_CNT_WIDTH,
    parameter int WR_DATA_W = 1,
    parameter int REUSE_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_W-1:0]     cfg_tile_len_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [WR_DATA_W-1:0] ld_data_i,
    input  logic                 sa_req_i,
    output logic                 sa_gnt_o,
    output logic                 sa_done_o,
    output logic                 wr_a_buf_valid_o,
    output logic                 wr_a_buf_id_o,
    output logic [CNT_W-1:0]     wr_a_buf_addr_o,
    output logic [WR_DATA_W-1:0] wr_a_buf_data_o,
    output logic                 rd_a_buf_valid_o,
    output logic                 rd_a_buf_id_o,
    output logic [CNT_W-1:0]     rd_a_buf_addr_o,
    output logic [1:0]           bank_full_o
`ifdef A_BUF_CTRL_REUSE_EN
    ,
    input  logic [REUSE_W-1:0]   reuse_cnt_i
`endif
);

    a_bank_state_e  bank_state [2];
    logic [CNT_W-1:0] bank_len [2];

    logic             wr_ptr;
    logic [CNT_W-1:0] wr_cnt;
    logic             rd_ptr;
    logic [CNT_W-1:0] rd_cnt;
    logic [REUSE_W-1:0] pass_left;
    logic [REUSE_W-1:0] reuse_val;

    a_drain_state_e drain_st;
    a_drain_state_e drain_nx;

    logic             accept;
    logic             fill_first;
    logic             fill_last;
    logic [CNT_W-1:0] fill_len;
    logic             grant;
    logic             release_bank;
    logic             rd_last_row;

`ifdef A_BUF_CTRL_REUSE_EN
    assign reuse_val = reuse_cnt_i;
`else
    assign reuse_val = '0;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        a_buf_bank_fsm #(.CNT_W(CNT_W)) u_bank (
            .clk          (clk),
            .rst_n        (rst_n),
            .fill_first   (fill_first && (int'(wr_ptr) == b)),
            .fill_last    (fill_last && (int'(wr_ptr) == b)),
            .grant        (grant && (int'(rd_ptr) == b)),
            .release_bank (release_bank && (int'(rd_ptr) == b)),
            .len_in       (cfg_tile_len_i),
            .state        (bank_state[b]),
            .len          (bank_len[b])
        );
    end

    // Fill side: the first beat of a tile uses the live cfg, later beats the latched length.
    assign ld_ready_o = (bank_state[wr_ptr] == EMPTY) || (bank_state[wr_ptr] == FILLING);
    assign accept     = ld_valid_i && ld_ready_o;
    assign fill_first = accept && (bank_state[wr_ptr] == EMPTY);
    assign fill_len   = fill_first ? cfg_tile_len_i : bank_len[wr_ptr];
    assign fill_last  = accept && (wr_cnt == fill_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr           <= 1'b0;
            wr_cnt           <= '0;
            wr_a_buf_valid_o <= 1'b0;
            wr_a_buf_id_o    <= 1'b0;
            wr_a_buf_addr_o  <= '0;
            wr_a_buf_data_o  <= '0;
        end else begin
            wr_a_buf_valid_o <= accept;
            if (accept) begin
                wr_a_buf_id_o   <= wr_ptr;
                wr_a_buf_addr_o <= wr_cnt;
                wr_a_buf_data_o <= ld_data_i;
            end
            if (fill_last) begin
                wr_ptr <= ~wr_ptr;
                wr_cnt <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    // Drain side.
    assign rd_last_row = (rd_cnt == bank_len[rd_ptr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_st <= IDLE;
        end else begin
            drain_st <= drain_nx;
        end
    end

    always_comb begin
        drain_nx         = drain_st;
        grant            = 1'b0;
        release_bank     = 1'b0;
        sa_gnt_o         = 1'b0;
        sa_done_o        = 1'b0;
        rd_a_buf_valid_o = 1'b0;
        case (drain_st)
            IDLE: begin
                if (sa_req_i && (bank_state[rd_ptr] == FULL)) begin
                    grant    = 1'b1;
                    sa_gnt_o = 1'b1;
                    drain_nx = DRAIN;
                end
            end
            DRAIN: begin
                rd_a_buf_valid_o = 1'b1;
                if (rd_last_row && (pass_left == '0)) begin
                    sa_done_o    = 1'b1;
                    release_bank = 1'b1;
                    drain_nx     = IDLE;
                end
            end
            default: drain_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 1'b0;
            rd_cnt    <= '0;
            pass_left <= '0;
        end else begin
            if (grant) begin
                rd_cnt    <= '0;
                pass_left <= reuse_val;
            end else if (drain_st == DRAIN) begin
                // Wrap straight into the next replay pass without a gap.
                if (rd_last_row) begin
                    rd_cnt <= '0;
                    if (pass_left != '0) begin
                        pass_left <= pass_left - REUSE_W'(1);
                    end
                end else begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
            end
            if (release_bank) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign rd_a_buf_id_o   = rd_ptr;
    assign rd_a_buf_addr_o = rd_cnt;
    assign bank_full_o     = {bank_state[1] == FULL, bank_state[0] == FULL};

endmodule

// File: tb/tb_a_buf_pingpong_ctrl.sv
// Directed bench for a_buf_pingpong_ctrl; exercises the reuse path when A_BUF_CTRL_REUSE_EN is defined.
module tb_a_buf_pingpong_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] cfg_len;
    logic       ld_valid;
    logic       ld_ready_o;
    logic       ld_data;
    logic       sa_req;
    logic       sa_gnt_o;
    logic       sa_done_o;
    logic       wr_valid_o;
    logic       wr_id_o;
    logic [7:0] wr_addr_o;
    logic       wr_data_o;
    logic       rd_valid_o;
    logic       rd_id_o;
    logic [7:0] rd_addr_o;
    logic [1:0] bank_full_o;
    logic [3:0] reuse_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       id;
        logic [7:0] addr;
        logic       data;
    } ev_t;

    ev_t wr_q[$];
    ev_t rd_q[$];
    int  gnt_q[$];
    int  done_q[$];

    a_buf_pingpong_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_tile_len_i   (cfg_len),
        .ld_valid_i       (ld_valid),
        .ld_ready_o       (ld_ready_o),
        .ld_data_i        (ld_data),
        .sa_req_i         (sa_req),
        .sa_gnt_o         (sa_gnt_o),
        .sa_done_o        (sa_done_o),
        .wr_a_buf_valid_o (wr_valid_o),
        .wr_a_buf_id_o    (wr_id_o),
        .wr_a_buf_addr_o  (wr_addr_o),
        .wr_a_buf_data_o  (wr_data_o),
        .rd_a_buf_valid_o (rd_valid_o),
        .rd_a_buf_id_o    (rd_id_o),
        .rd_a_buf_addr_o  (rd_addr_o),
        .bank_full_o      (bank_full_o)
`ifdef A_BUF_CTRL_REUSE_EN
        ,
        .reuse_cnt_i      (reuse_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event recorder: samples on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid_o) wr_q.push_back('{cyc, wr_id_o, wr_addr_o, wr_data_o});
            if (rd_valid_o) rd_q.push_back('{cyc, rd_id_o, rd_addr_o, 1'b0});
            if (sa_gnt_o)   gnt_q.push_back(cyc);
            if (sa_done_o)  done_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        wr_q.delete();
        rd_q.delete();
        gnt_q.delete();
        done_q.delete();
    endtask

    task automatic do_reset();
        ld_valid  = 1'b0;
        ld_data   = 1'b0;
        cfg_len   = 8'd0;
        sa_req    = 1'b0;
        reuse_cnt = 4'd0;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_q();
        tick();
    endtask

    task automatic send_beat(input logic d, input logic [7:0] len);
        int k = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        cfg_len  = len;
        #1;
        while (!ld_ready_o && k < 60) begin
            tick();
            k++;
        end
        if (!ld_ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_beat_timeout ready=%0b exp 1", ld_ready_o);
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int max_cyc);
        int k = 0;
        while (done_q.size() < n && k < max_cyc) begin
            tick();
            k++;
        end
        checks++;
        if (done_q.size() < n) begin
            errors++;
            $display("FAIL wait_done got %0d exp %0d", done_q.size(), n);
        end
    endtask

    task automatic check_reads(input string name, input int n, input int split, input int len_a, input int len_b);
        checks++;
        if (rd_q.size() !== n) begin
            errors++;
            $display("FAIL %s_rd_count got %0d exp %0d", name, rd_q.size(), n);
        end
        for (int i = 0; i < n && i < rd_q.size(); i++) begin
            logic       exp_id;
            logic [7:0] exp_addr;
            exp_id   = (i >= split);
            exp_addr = (i >= split) ? 8'(i - split) : 8'(i);
            if (i >= split && len_b < 0) exp_addr = 8'(i);
            checks++;
            if (rd_q[i].id !== exp_id || rd_q[i].addr !== exp_addr) begin
                errors++;
                $display("FAIL %s_rd[%0d] got id%0d/%0d exp id%0d/%0d", name, i, rd_q[i].id, rd_q[i].addr, exp_id, exp_addr);
            end
        end
        if (len_a < 0) $display("note %s", name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld_valid = 1'b0; ld_data = 1'b0; cfg_len = 8'd0; sa_req = 1'b0; reuse_cnt = 4'd0;
        repeat (2) tick();
        checks++;
        if ({wr_valid_o, wr_id_o, wr_addr_o, wr_data_o} !== 11'd0) begin
            errors++;
            $display("FAIL reset_wr got %0h exp 0", {wr_valid_o, wr_id_o, wr_addr_o, wr_data_o});
        end
        checks++;
        if ({rd_valid_o, rd_id_o, rd_addr_o} !== 10'd0) begin
            errors++;
            $display("FAIL reset_rd got %0h exp 0", {rd_valid_o, rd_id_o, rd_addr_o});
        end
        checks++;
        if ({sa_gnt_o, sa_done_o, bank_full_o} !== 4'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %0h exp 0", {sa_gnt_o, sa_done_o, bank_full_o});
        end
        checks++;
        if (ld_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b exp 1", ld_ready_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_tile();
        logic [3:0] pat;
        pat = 4'b1101;
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(pat[i], 8'd3);
        checks++;
        if (bank_full_o !== 2'b01 || ld_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_full got %b/%b exp 01/1", bank_full_o, ld_ready_o);
        end
        sa_req = 1'b1;
        #1;
        checks++;
        if (sa_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt got %0b exp 1", sa_gnt_o);
        end
        tick();
        sa_req = 1'b0;
        wait_done(1, 20);
        tick();
        checks++;
        if (wr_q.size() !== 4) begin
            errors++;
            $display("FAIL single_wr_count got %0d exp 4", wr_q.size());
        end
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i].id !== 1'b0 || wr_q[i].addr !== 8'(i) || wr_q[i].data !== pat[i]) begin
                errors++;
                $display("FAIL single_wr[%0d] got id%0d/%0d/%0d exp id0/%0d/%0d", i, wr_q[i].id, wr_q[i].addr, wr_q[i].data, i, pat[i]);
            end
        end
        check_reads("single", 4, 4, 3, 0);
        if (rd_q.size() == 4 && gnt_q.size() == 1 && done_q.size() == 1) begin
            checks++;
            if (rd_q[0].cyc !== gnt_q[0] + 1 || rd_q[3].cyc !== rd_q[0].cyc + 3 || done_q[0] !== rd_q[3].cyc) begin
                errors++;
                $display("FAIL single_timing got gnt%0d rd%0d..%0d done%0d exp rd=gnt+1, contiguous, done=last", gnt_q[0], rd_q[0].cyc, rd_q[3].cyc, done_q[0]);
            end
        end
        checks++;
        if (bank_full_o !== 2'b00) begin
            errors++;
            $display("FAIL single_released got %b exp 00", bank_full_o);
        end
    endtask

    task automatic test_pingpong();
        do_reset();
        sa_req = 1'b1;
        for (int i = 0; i < 16; i++) send_beat((i % 3) == 0, 8'd7);
        wait_done(2, 60);
        sa_req = 1'b0;
        tick();
        checks++;
        if (wr_q.size() !== 16) begin
            errors++;
            $display("FAIL pingpong_wr_count got %0d exp 16", wr_q.size());
        end
        for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i].id !== (i >= 8) || wr_q[i].addr !== 8'(i % 8) || wr_q[i].data !== ((i % 3) == 0)) begin
                errors++;
                $display("FAIL pingpong_wr[%0d] got id%0d/%0d/%0d exp id%0d/%0d/%0d", i, wr_q[i].id, wr_q[i].addr, wr_q[i].data, (i >= 8), i % 8, (i % 3) == 0);
            end
        end
        check_reads("pingpong", 16, 8, 7, 7);
        if (rd_q.size() == 16 && wr_q.size() == 16 && gnt_q.size() == 2 && done_q.size() == 2) begin
            checks++;
            if (rd_q[0].cyc >= wr_q[15].cyc) begin
                errors++;
                $display("FAIL pingpong_overlap got rd0@%0d exp before last wr@%0d", rd_q[0].cyc, wr_q[15].cyc);
            end
            checks++;
            if (gnt_q[1] - done_q[0] !== 1 || rd_q[8].cyc - rd_q[7].cyc !== 2) begin
                errors++;
                $display("FAIL pingpong_gap got gnt-done=%0d rd gap=%0d exp 1/2", gnt_q[1] - done_q[0], rd_q[8].cyc - rd_q[7].cyc);
            end
            checks++;
            if (done_q[1] !== rd_q[15].cyc) begin
                errors++;
                $display("FAIL pingpong_done2 got %0d exp %0d", done_q[1], rd_q[15].cyc);
            end
        end
    endtask

    task automatic test_back_pressure();
        int k = 0;
        do_reset();
        for (int i = 0; i < 6; i++) send_beat(1'b1, 8'd2);
        checks++;
        if (bank_full_o !== 2'b11 || ld_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got %b/%b exp 11/0", bank_full_o, ld_ready_o);
        end
        ld_valid = 1'b1;
        cfg_len  = 8'd2;
        repeat (3) tick();
        checks++;
        if (wr_q.size() !== 6) begin
            errors++;
            $display("FAIL bp_no_write got %0d exp 6", wr_q.size());
        end
        sa_req = 1'b1;
        while (!sa_done_o && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (sa_done_o !== 1'b1 || ld_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_done_cycle got done%0b ready%0b exp 1/0", sa_done_o, ld_ready_o);
        end
        tick();
        checks++;
        if (ld_ready_o !== 1'b1 || bank_full_o !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got ready%0b full%b exp 1/10", ld_ready_o, bank_full_o);
        end
        ld_valid = 1'b0;
        sa_req   = 1'b0;
        tick();
    endtask

    task automatic test_underflow();
        int bad = 0;
        do_reset();
        sa_req = 1'b1;
        #1;
        repeat (5) begin
            if (sa_gnt_o || rd_valid_o) bad++;
            tick();
        end
        checks++;
        if (bad !== 0 || gnt_q.size() !== 0 || rd_q.size() !== 0) begin
            errors++;
            $display("FAIL underflow_idle got %0d bad cycles exp 0", bad);
        end
        send_beat(1'b0, 8'd1);
        send_beat(1'b1, 8'd1);
        checks++;
        if (bank_full_o !== 2'b01 || sa_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL underflow_gnt got full%b gnt%0b exp 01/1", bank_full_o, sa_gnt_o);
        end
        tick();
        sa_req = 1'b0;
        wait_done(1, 20);
        tick();
        check_reads("underflow", 2, 2, 1, 0);
    endtask

    task automatic test_cfg_midfill();
        do_reset();
        send_beat(1'b1, 8'd5);
        send_beat(1'b0, 8'd5);
        for (int i = 2; i < 5; i++) send_beat(1'b1, 8'd2);
        checks++;
        if (bank_full_o !== 2'b00) begin
            errors++;
            $display("FAIL cfg_not_full got %b exp 00", bank_full_o);
        end
        send_beat(1'b0, 8'd2);
        checks++;
        if (bank_full_o !== 2'b01) begin
            errors++;
            $display("FAIL cfg_full6 got %b exp 01", bank_full_o);
        end
        for (int i = 0; i < 3; i++) send_beat(1'b1, 8'd2);
        checks++;
        if (bank_full_o !== 2'b11) begin
            errors++;
            $display("FAIL cfg_full3 got %b exp 11", bank_full_o);
        end
        sa_req = 1'b1;
        wait_done(2, 40);
        sa_req = 1'b0;
        tick();
        check_reads("cfg", 9, 6, 5, 2);
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(1'b1, 8'd3);
        sa_req = 1'b1;
        tick();
        sa_req = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_valid_o, rd_id_o, rd_addr_o, sa_gnt_o, sa_done_o, wr_valid_o, bank_full_o} !== 15'd0 || ld_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_drain got rd%0b addr%0d full%b ready%0b exp 0/0/00/1", rd_valid_o, rd_addr_o, bank_full_o, ld_ready_o);
        end
        tick();
        rst_n = 1'b1;
        clear_q();
        sa_req = 1'b1;
        repeat (4) tick();
        sa_req = 1'b0;
        checks++;
        if (rd_q.size() !== 0 || gnt_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_drain_after got rd%0d gnt%0d exp 0/0", rd_q.size(), gnt_q.size());
        end
    endtask

`ifdef A_BUF_CTRL_REUSE_EN
    task automatic test_reuse();
        do_reset();
        reuse_cnt = 4'd2;
        send_beat(1'b1, 8'd1);
        send_beat(1'b0, 8'd1);
        sa_req = 1'b1;
        tick();
        sa_req = 1'b0;
        reuse_cnt = 4'd0;
        wait_done(1, 30);
        repeat (3) tick();
        checks++;
        if (rd_q.size() !== 6 || done_q.size() !== 1) begin
            errors++;
            $display("FAIL reuse_count got rd%0d done%0d exp 6/1", rd_q.size(), done_q.size());
        end
        for (int i = 0; i < 6 && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i].addr !== 8'(i % 2) || rd_q[i].id !== 1'b0 || rd_q[i].cyc !== rd_q[0].cyc + i) begin
                errors++;
                $display("FAIL reuse_rd[%0d] got addr%0d@%0d exp %0d@%0d", i, rd_q[i].addr, rd_q[i].cyc, i % 2, rd_q[0].cyc + i);
            end
        end
        if (rd_q.size() == 6 && done_q.size() == 1) begin
            checks++;
            if (done_q[0] !== rd_q[5].cyc) begin
                errors++;
                $display("FAIL reuse_done got %0d exp %0d", done_q[0], rd_q[5].cyc);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_tile();
        test_pingpong();
        test_back_pressure();
        test_underflow();
        test_cfg_midfill();
        test_reset_mid_drain();
`ifdef A_BUF_CTRL_REUSE_EN
        test_reuse();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time %0t exp finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
